// File: rtl/ltc5548_sys_timer_host.sv
// Avalon-MM master that programs and services a 16-bit interval-timer slave
// and reports serviced timeouts (tick, running count, counter snapshot) to the
// LTC5548 sampling logic.
//
// Handshakes: cfg_start and cfg_stop are single-cycle requests sampled on the
// rising clock edge. cfg_start is accepted only in IDLE; cfg_stop is honoured
// in any other state once the bus access in flight completes. On the slave
// side there is no waitrequest: each access lasts exactly one cycle with
// chipselect=1 (write_n=0 for a write), and read data is sampled from
// m_readdata on the cycle after the read address was presented.
module ltc5548_sys_timer_host #(
  parameter bit CONTINUOUS = 1'b1,
  parameter bit SNAP_EN    = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      cfg_period,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic [31:0]      snap_value,
  output logic             snap_valid,
  output logic [2:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [15:0]      m_writedata,
  input  logic [15:0]      m_readdata,
  input  logic             irq,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTL, S_WAIT, S_CLR,
    S_SNAP, S_RD_L, S_RD_H, S_DONE, S_STOP
  } state_t;

  localparam logic [15:0] CTL_RUN  = CONTINUOUS ? 16'h0007 : 16'h0005;
  localparam logic [15:0] CTL_STOP = 16'h0008;

  state_t             state_q, state_d;
  logic               stop_pend_q, stop_pend_d;
  logic [31:0]        period_q, period_d;
  logic [15:0]        snap_l_q, snap_l_d;
  logic               busy_q, busy_d;
  logic               tick_q, tick_d;
  logic [CNT_W-1:0]   tick_count_q, tick_count_d;
  logic [31:0]        snap_value_q, snap_value_d;
  logic               snap_valid_q, snap_valid_d;
  logic [2:0]         addr_q, addr_d;
  logic               cs_q, cs_d;
  logic               wn_q, wn_d;
  logic [15:0]        wd_q, wd_d;

  // Next-state logic; a stop seen in RD_H is held so the tick still goes out.
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    period_d    = period_q;
    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (cfg_start) begin
          state_d  = S_WR_PL;
          period_d = cfg_period;
        end
      end
      S_WR_PL:  state_d = cfg_stop ? S_STOP : S_WR_PH;
      S_WR_PH:  state_d = cfg_stop ? S_STOP : S_WR_CTL;
      S_WR_CTL: state_d = cfg_stop ? S_STOP : S_WAIT;
      S_WAIT: begin
        if (cfg_stop)  state_d = S_STOP;
        else if (irq)  state_d = S_CLR;
      end
      S_CLR: begin
        if (cfg_stop)     state_d = S_STOP;
        else if (SNAP_EN) state_d = S_SNAP;
        else              state_d = S_DONE;
      end
      S_SNAP:   state_d = cfg_stop ? S_STOP : S_RD_L;
      S_RD_L:   state_d = cfg_stop ? S_STOP : S_RD_H;
      S_RD_H: begin
        if (cfg_stop) stop_pend_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        stop_pend_d = 1'b0;
        if (cfg_stop || stop_pend_q) state_d = S_STOP;
        else if (CONTINUOUS)         state_d = S_WAIT;
        else                         state_d = S_IDLE;
      end
      S_STOP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so each access is registered
  // and lines up with the cycle the FSM spends in that state.
  always_comb begin
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 3'd0;
    wd_d   = 16'h0000;
    case (state_d)
      S_WR_PL:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = period_d[15:0];  end
      S_WR_PH:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = period_d[31:16]; end
      S_WR_CTL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = CTL_RUN;         end
      S_CLR:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0;                         end
      S_SNAP:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4;                         end
      S_RD_L:   begin cs_d = 1'b1;              addr_d = 3'd4;                         end
      S_RD_H:   begin cs_d = 1'b1;              addr_d = 3'd5;                         end
      S_STOP:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = CTL_STOP;        end
      default:  begin end
    endcase
  end

  // Status outputs: tick/snapshot are registered out of DONE; the count
  // restarts from zero on every accepted start.
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    tick_d       = (state_q == S_DONE);
    snap_valid_d = (state_q == S_DONE) && SNAP_EN;
    tick_count_d = tick_count_q;
    snap_l_d     = snap_l_q;
    snap_value_d = snap_value_q;
    if (state_q == S_IDLE && cfg_start) tick_count_d = '0;
    else if (state_q == S_DONE)         tick_count_d = tick_count_q + CNT_W'(1);
    if (state_q == S_RD_H) snap_l_d = m_readdata;
    if (state_q == S_DONE && SNAP_EN) snap_value_d = {m_readdata, snap_l_q};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      stop_pend_q  <= 1'b0;
      period_q     <= 32'h0;
      snap_l_q     <= 16'h0;
      busy_q       <= 1'b0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
      snap_value_q <= 32'h0;
      snap_valid_q <= 1'b0;
      addr_q       <= 3'd0;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      wd_q         <= 16'h0;
    end else begin
      state_q      <= state_d;
      stop_pend_q  <= stop_pend_d;
      period_q     <= period_d;
      snap_l_q     <= snap_l_d;
      busy_q       <= busy_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
      addr_q       <= addr_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      wd_q         <= wd_d;
    end
  end

  assign busy         = busy_q;
  assign tick         = tick_q;
  assign tick_count   = tick_count_q;
  assign snap_value   = snap_value_q;
  assign snap_valid   = snap_valid_q;
  assign m_address    = addr_q;
  assign m_chipselect = cs_q;
  assign m_write_n    = wn_q;
  assign m_writedata  = wd_q;
  assign dbg_state    = state_q;

endmodule
